// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_gen
//  Description : Parametrised VGA raster timing generator. Free-running
//                horizontal/vertical position counters, advanced by a pixel
//                clock enable, drive fully registered sync, active-video,
//                coordinate and line/frame start outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int COL_W    = 10,
    parameter int ROW_W    = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    output logic             H_Sync,
    output logic             V_Sync,
    output logic             Active,
    output logic [COL_W-1:0] Col,
    output logic [ROW_W-1:0] Row,
    output logic             Line_Start,
    output logic             Frame_Start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Decode thresholds, sized to the counters. The sync-end bounds get one
    // extra bit so a zero back porch cannot overflow the counter width.
    localparam logic [COL_W-1:0] c_h_last     = COL_W'(H_TOTAL - 1);
    localparam logic [ROW_W-1:0] c_v_last     = ROW_W'(V_TOTAL - 1);
    localparam logic [COL_W-1:0] c_h_active   = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] c_v_active   = ROW_W'(V_ACTIVE);
    localparam logic [COL_W:0]   c_hs_start   = (COL_W+1)'(H_ACTIVE + H_FP);
    localparam logic [COL_W:0]   c_hs_end     = (COL_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [ROW_W:0]   c_vs_start   = (ROW_W+1)'(V_ACTIVE + V_FP);
    localparam logic [ROW_W:0]   c_vs_end     = (ROW_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [COL_W-1:0] r_hc;
    logic [ROW_W-1:0] r_vc;

    logic             w_h_in_sync;
    logic             w_v_in_sync;
    logic             w_active;
    logic             w_h_zero;
    logic             w_v_zero;
    logic             w_h_wrap;
    logic             w_v_wrap;

    // Decode of the current raster position; registered into the outputs
    // so that every output describes the same (Col, Row) pair.
    always_comb begin
        w_h_in_sync = ({1'b0, r_hc} >= c_hs_start) && ({1'b0, r_hc} < c_hs_end);
        w_v_in_sync = ({1'b0, r_vc} >= c_vs_start) && ({1'b0, r_vc} < c_vs_end);
        w_active    = (r_hc < c_h_active) && (r_vc < c_v_active);
        w_h_zero    = (r_hc == '0);
        w_v_zero    = (r_vc == '0);
        w_h_wrap    = (r_hc == c_h_last);
        w_v_wrap    = (r_vc == c_v_last);
    end

    // Position counters: hc steps every enabled pixel, vc steps on hc wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (CE) begin
            if (w_h_wrap) begin
                r_hc <= '0;
                if (w_v_wrap) begin
                    r_vc <= '0;
                end else begin
                    r_vc <= r_vc + 1'b1;
                end
            end else begin
                r_hc <= r_hc + 1'b1;
            end
        end
    end

    // Registered outputs: levels hold while CE is low, strobes drop to zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Col         <= '0;
            Row         <= '0;
            Active      <= 1'b0;
            H_Sync      <= ~H_POL;
            V_Sync      <= ~V_POL;
            Line_Start  <= 1'b0;
            Frame_Start <= 1'b0;
        end else if (CE) begin
            Col         <= r_hc;
            Row         <= r_vc;
            Active      <= w_active;
            H_Sync      <= w_h_in_sync ? H_POL : ~H_POL;
            V_Sync      <= w_v_in_sync ? V_POL : ~V_POL;
            Line_Start  <= w_h_zero;
            Frame_Start <= w_h_zero && w_v_zero;
        end else begin
            Line_Start  <= 1'b0;
            Frame_Start <= 1'b0;
        end
    end

endmodule
`default_nettype wire
